dragster_line_capture: RTL and testbench

Captures one Dragster linear-sensor line at a time, after the sensor has been configured over SPI, and presents it as an 8-bit stream with start-of-line and end-of-line markers. It sits directly downstream of the sensor configuration stage: capture is armed only once configuration completes. Pixels are buffered in a small first-word-fall-through FIFO so downstream back-pressure is absorbed; overflow and malformed lines are flagged and counted.

---
 rtl/dragster_line_capture_if.sv | 12 +
 rtl/dragster_line_capture.sv | 129 ++++++++++++
 tb/tb_dragster_line_capture.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dragster_line_capture_if.sv
// Output pixel stream of the Dragster line capture: 8-bit data with
// start-of-line (tuser) and end-of-line (tlast) markers.
interface dragster_line_capture_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tuser;
   logic       tlast;

   modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/dragster_line_capture.sv
// Captures one Dragster sensor line at a time into a small FWFT FIFO and
// streams it out with line markers; flags overflow and short lines.
module dragster_line_capture #(
   parameter int unsigned LINE_LENGTH = 2048,
   parameter int unsigned FIFO_DEPTH  = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic                           clear_status,
   input  logic [7:0]                     sensor_data,
   input  logic                           sensor_data_valid,
   input  logic                           sensor_line_start,
   dragster_line_capture_if.master        m,
   output logic                           capturing,
   output logic [15:0]                    line_count,
   output logic                           overflow,
   output logic                           short_line
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [15:0] LAST_IDX = 16'(LINE_LENGTH - 1);

   typedef enum logic [1:0] {IDLE, WAIT_LINE, CAPTURE, DROP} state_t;

   typedef struct packed {
      logic       user;
      logic       last;
      logic [7:0] data;
   } pixel_t;

   state_t          state;
   logic [15:0]     pix_cnt;
   pixel_t          mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;

   logic            pop_c;
   logic            full_c;
   logic            start_c;
   logic            wr_req_c;
   logic            wr_ok_c;
   logic            drop_c;
   logic            line_end_c;
   logic            short_c;
   logic            capt_next_c;
   logic [15:0]     idx_c;
   logic [AW-1:0]   rd_next_c;
   logic [CW-1:0]   avail_c;

   // Write decision for this cycle's pixel and FIFO bookkeeping
   always_comb begin
      pop_c     = m.tvalid & m.tready;
      full_c    = (count == CW'(FIFO_DEPTH));
      start_c   = 1'b0;
      case (state)
         WAIT_LINE, DROP: start_c = enable & sensor_line_start;
         CAPTURE:         start_c = sensor_line_start;
         default:         start_c = 1'b0;
      endcase
      idx_c       = start_c ? 16'd0 : pix_cnt;
      wr_req_c    = sensor_data_valid & (start_c | (state == CAPTURE));
      wr_ok_c     = wr_req_c & (~full_c | pop_c);
      drop_c      = wr_req_c & ~wr_ok_c;
      line_end_c  = wr_ok_c & (idx_c == LAST_IDX);
      short_c     = (state == CAPTURE) & sensor_line_start & (pix_cnt != 16'd0);
      capt_next_c = (start_c | (state == CAPTURE)) & ~drop_c & ~line_end_c;
      rd_next_c   = rd_ptr + AW'(pop_c);
      avail_c     = count - CW'(pop_c);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pix_cnt    <= 16'd0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         m.tvalid   <= 1'b0;
         m.tdata    <= 8'd0;
         m.tuser    <= 1'b0;
         m.tlast    <= 1'b0;
         capturing  <= 1'b0;
         line_count <= 16'd0;
         overflow   <= 1'b0;
         short_line <= 1'b0;
      end else begin
         if (wr_ok_c) begin
            mem[wr_ptr] <= '{user: (idx_c == 16'd0), last: (idx_c == LAST_IDX), data: sensor_data};
            wr_ptr      <= wr_ptr + AW'(1);
         end
         count  <= count + CW'(wr_ok_c) - CW'(pop_c);
         rd_ptr <= rd_next_c;

         // Output register shows the head entry written on an earlier edge
         m.tvalid <= (avail_c != '0);
         if (avail_c != '0) begin
            m.tdata <= mem[rd_next_c].data;
            m.tuser <= mem[rd_next_c].user;
            m.tlast <= mem[rd_next_c].last;
         end

         case (state)
            IDLE: if (enable) state <= WAIT_LINE;
            WAIT_LINE, DROP: begin
               if (!enable)                state <= IDLE;
               else if (sensor_line_start) state <= CAPTURE;
            end
            default: ;
         endcase
         if (drop_c)          state <= DROP;
         else if (line_end_c) state <= enable ? WAIT_LINE : IDLE;

         if (wr_ok_c)      pix_cnt <= idx_c + 16'd1;
         else if (start_c) pix_cnt <= 16'd0;

         capturing <= capt_next_c;

         // Setting events take priority over clear_status
         if (drop_c)            overflow <= 1'b1;
         else if (clear_status) overflow <= 1'b0;
         if (short_c)           short_line <= 1'b1;
         else if (clear_status) short_line <= 1'b0;
         if (line_end_c)        line_count <= line_count + 16'd1;
         else if (clear_status) line_count <= 16'd0;
      end
   end
endmodule

// File: tb/tb_dragster_line_capture.sv
// Randomized and directed bench for dragster_line_capture against a
// queue-based behavioural model.
module tb_dragster_line_capture;
   localparam int unsigned LL = 8;
   localparam int unsigned FD = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        clear_status = 1'b0;
   logic [7:0]  sensor_data = 8'd0;
   logic        sensor_data_valid = 1'b0;
   logic        sensor_line_start = 1'b0;
   logic        capturing;
   logic [15:0] line_count;
   logic        overflow;
   logic        short_line;

   dragster_line_capture_if mif ();

   dragster_line_capture #(.LINE_LENGTH(LL), .FIFO_DEPTH(FD)) dut (
      .clk               (clk),
      .reset             (reset),
      .enable            (enable),
      .clear_status      (clear_status),
      .sensor_data       (sensor_data),
      .sensor_data_valid (sensor_data_valid),
      .sensor_line_start (sensor_line_start),
      .m                 (mif),
      .capturing         (capturing),
      .line_count        (line_count),
      .overflow          (overflow),
      .short_line        (short_line)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       u;
      logic       l;
   } ent_t;

   int checks = 0;
   int failures = 0;

   // Model state: FIFO contents with the edge each entry was written on
   ent_t        q[$];
   int          qw[$];
   ent_t        rec[$];
   bit          live = 0;
   int          edge_no = 0;
   int          mode = 0;      // 0 off, 1 waiting for line, 2 in a line, 3 discarding
   int          pos = 0;
   logic [15:0] m_lines = 16'd0;
   bit          m_ovf = 0;
   bit          m_short = 0;
   bit          exp_valid = 0;
   ent_t        exp_ent = '0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      int  occ;
      bit  pop, want, bump, set_ovf, set_short;
      edge_no++;
      if (reset) begin
         q.delete(); qw.delete();
         mode = 0; pos = 0; m_lines = 16'd0; m_ovf = 0; m_short = 0;
         exp_valid = 0; exp_ent = '0;
         live = 1;
      end else if (live) begin
         if (mif.tvalid && mif.tready) rec.push_back('{d: mif.tdata, u: mif.tuser, l: mif.tlast});
         occ = q.size();
         pop = exp_valid && mif.tready;
         if (pop) begin void'(q.pop_front()); void'(qw.pop_front()); end
         want = 0; bump = 0; set_ovf = 0; set_short = 0;
         case (mode)
            0: if (enable) mode = 1;
            1, 3: begin
               if (!enable) mode = 0;
               else if (sensor_line_start) begin
                  mode = 2; pos = 0; want = sensor_data_valid;
               end
            end
            default: begin
               if (sensor_line_start) begin
                  if (pos != 0) set_short = 1;
                  pos = 0;
               end
               want = sensor_data_valid;
            end
         endcase
         if (want) begin
            if (occ == FD && !pop) begin
               set_ovf = 1; mode = 3;
            end else begin
               q.push_back('{d: sensor_data, u: (pos == 0), l: (pos == LL - 1)});
               qw.push_back(edge_no);
               if (pos == LL - 1) begin bump = 1; mode = enable ? 1 : 0; end
               else pos++;
            end
         end
         if (set_ovf) m_ovf = 1; else if (clear_status) m_ovf = 0;
         if (set_short) m_short = 1; else if (clear_status) m_short = 0;
         if (bump) m_lines = m_lines + 16'd1; else if (clear_status) m_lines = 16'd0;
         exp_valid = (q.size() > 0) && (qw[0] < edge_no);
         if (exp_valid) exp_ent = q[0];
      end
   end

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (live) begin
         cmp("m_tvalid", 32'(mif.tvalid), 32'(exp_valid));
         if (exp_valid) begin
            cmp("m_tdata", 32'(mif.tdata), 32'(exp_ent.d));
            cmp("m_tuser", 32'(mif.tuser), 32'(exp_ent.u));
            cmp("m_tlast", 32'(mif.tlast), 32'(exp_ent.l));
         end
         cmp("capturing", 32'(capturing), 32'(mode == 2));
         cmp("line_count", 32'(line_count), 32'(m_lines));
         cmp("overflow", 32'(overflow), 32'(m_ovf));
         cmp("short_line", 32'(short_line), 32'(m_short));
      end
   end

   task automatic px(input logic v, input logic ls, input logic [7:0] d);
      sensor_data_valid = v; sensor_line_start = ls; sensor_data = d;
      @(negedge clk);
      sensor_data_valid = 1'b0; sensor_line_start = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) px(1'b0, 1'b0, 8'd0);
   endtask

   task automatic send_line(input logic [7:0] base, input int n);
      for (int i = 0; i < n; i++) px(1'b1, (i == 0), base + 8'(i));
   endtask

   task automatic clr();
      clear_status = 1'b1;
      @(negedge clk);
      clear_status = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 64 && (q.size() != 0 || exp_valid); i++) @(negedge clk);
      cmp(name, 32'(q.size() == 0 && !exp_valid), 32'd1);
      idle(1);
   endtask

   task automatic rec_masks(output int um, output int lm);
      um = 0; lm = 0;
      for (int i = 0; i < rec.size() && i < 31; i++) begin
         if (rec[i].u) um |= (1 << i);
         if (rec[i].l) lm |= (1 << i);
      end
   endtask

   initial begin
      int um, lm;
      mif.tready = 1'b0;
      repeat (3) @(negedge clk);
      cmp("rst_tvalid", 32'(mif.tvalid), 32'd0);
      cmp("rst_tdata", 32'(mif.tdata), 32'd0);
      cmp("rst_tuser_tlast", 32'({mif.tuser, mif.tlast}), 32'd0);
      cmp("rst_status", 32'({capturing, overflow, short_line}), 32'd0);
      cmp("rst_line_count", 32'(line_count), 32'd0);
      reset = 1'b0;

      // Basic line
      enable = 1'b1; mif.tready = 1'b1;
      idle(1);
      rec.delete();
      send_line(8'h10, 8);
      drain("t1_drain");
      cmp("t1_len", 32'(rec.size()), 32'd8);
      for (int i = 0; i < rec.size(); i++) cmp("t1_data", 32'(rec[i].d), 32'h10 + 32'(i));
      rec_masks(um, lm);
      cmp("t1_user", 32'(um), 32'h01);
      cmp("t1_last", 32'(lm), 32'h80);
      cmp("t1_line_count", 32'(line_count), 32'd1);
      cmp("t1_model_lines", 32'(m_lines), 32'd1);
      cmp("t1_flags", 32'({overflow, short_line}), 32'd0);

      // Disabled capture
      clr(); enable = 1'b0; idle(2); rec.delete();
      send_line(8'hA0, 8); idle(3);
      cmp("t2_len", 32'(rec.size()), 32'd0);
      cmp("t2_line_count", 32'(line_count), 32'd0);
      cmp("t2_tvalid", 32'(mif.tvalid), 32'd0);
      enable = 1'b1; idle(1);

      // Short line followed by a full line
      rec.delete();
      send_line(8'h60, 3); send_line(8'h70, 8);
      drain("t3_drain");
      rec_masks(um, lm);
      cmp("t3_len", 32'(rec.size()), 32'd11);
      cmp("t3_user", 32'(um), 32'h009);
      cmp("t3_last", 32'(lm), 32'h400);
      cmp("t3_short", 32'(short_line), 32'd1);
      cmp("t3_line_count", 32'(line_count), 32'd1);

      // Overflow with stalled sink, then recovery
      clr(); rec.delete(); mif.tready = 1'b0;
      send_line(8'h20, 8); idle(1);
      cmp("t4_overflow", 32'(overflow), 32'd1);
      cmp("t4_model_ovf", 32'(m_ovf), 32'd1);
      cmp("t4_capturing", 32'(capturing), 32'd0);
      mif.tready = 1'b1;
      drain("t4_drain_a");
      send_line(8'h30, 8);
      drain("t4_drain_b");
      cmp("t4_len", 32'(rec.size()), 32'd12);
      for (int i = 0; i < rec.size(); i++)
         cmp("t4_data", 32'(rec[i].d), (i < 4) ? 32'h20 + 32'(i) : 32'h30 + 32'(i - 4));
      rec_masks(um, lm);
      cmp("t4_user", 32'(um), 32'h011);
      cmp("t4_last", 32'(lm), 32'h800);
      cmp("t4_line_count", 32'(line_count), 32'd1);

      // Full FIFO with simultaneous pop and push
      clr(); rec.delete(); mif.tready = 1'b0;
      send_line(8'h40, 4);
      mif.tready = 1'b1;
      for (int i = 4; i < 8; i++) px(1'b1, 1'b0, 8'h40 + 8'(i));
      drain("t5_drain");
      cmp("t5_overflow", 32'(overflow), 32'd0);
      cmp("t5_len", 32'(rec.size()), 32'd8);
      for (int i = 0; i < rec.size(); i++) cmp("t5_data", 32'(rec[i].d), 32'h40 + 32'(i));
      cmp("t5_line_count", 32'(line_count), 32'd1);

      // Reset in the middle of a line
      send_line(8'h80, 3);
      reset = 1'b1; @(negedge clk);
      cmp("t6_tvalid", 32'(mif.tvalid), 32'd0);
      cmp("t6_status", 32'({capturing, overflow, short_line}), 32'd0);
      cmp("t6_line_count", 32'(line_count), 32'd0);
      reset = 1'b0; idle(1); rec.delete();
      send_line(8'h90, 8);
      drain("t6_drain");
      cmp("t6_len", 32'(rec.size()), 32'd8);
      if (rec.size() == 8) begin
         cmp("t6_first", 32'({rec[0].d, rec[0].u}), {23'd0, 8'h90, 1'b1});
         cmp("t6_last", 32'({rec[7].d, rec[7].l}), {23'd0, 8'h97, 1'b1});
      end
      cmp("t6_line_count_after", 32'(line_count), 32'd1);

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 99) == 0) enable = ~enable;
         clear_status      = ($urandom_range(0, 199) == 0);
         reset             = ($urandom_range(0, 999) == 0);
         sensor_data_valid = ($urandom_range(0, 3) != 0);
         sensor_line_start = ($urandom_range(0, 11) == 0);
         sensor_data       = 8'($urandom);
         mif.tready        = ($urandom_range(0, 9) < 6);
         @(negedge clk);
      end
      reset = 1'b0; clear_status = 1'b0;
      sensor_data_valid = 1'b0; sensor_line_start = 1'b0;
      mif.tready = 1'b1;
      drain("rand_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
